piso_serializer: RTL
====================

PISO_SERIALIZER -- requirements
Module: piso_serializer

Interface
REQ-001 The block SHALL have parameter SIZE, default 256, giving the word width in bits and the number of serial bits per frame.
REQ-002 The block SHALL have parameter CNT_W, default 8, giving the bit-counter width; it SHALL satisfy 2**CNT_W >= SIZE.
REQ-003 Port clk SHALL be an input, 1 bit: clock; all state updates on the rising edge.
REQ-004 Port reset SHALL be an input, 1 bit: reset, asynchronous, active-high.
REQ-005 Port in_data SHALL be an input, SIZE bits: parallel word to serialize.
REQ-006 Port in_valid SHALL be an input, 1 bit: in_data is valid.
REQ-007 Port in_ready SHALL be an output, 1 bit: the block accepts a word this cycle.
REQ-008 Port abort SHALL be an input, 1 bit: synchronous cancel of the current frame.
REQ-009 Port s_out SHALL be an output, 1 bit: serial data; it drives s_in of the downstream sipo_shift_register on the same clk.
REQ-010 Port s_active SHALL be an output, 1 bit: s_out carries a frame bit this cycle.
REQ-011 Port frame_done SHALL be an output, 1 bit: one-cycle pulse; the downstream p_out holds the complete word.

Function
REQ-012 FSM states SHALL be IDLE and SHIFT.
REQ-013 In IDLE: in_ready=1, s_active=0, s_out=0.
REQ-014 Accept SHALL occur when in_valid and in_ready are both high at a clock edge; the accepting edge loads the shift register with in_data, clears bit_cnt to 0 and moves the FSM to SHIFT.
REQ-015 In SHIFT, in cycle k (k=0..SIZE-1): s_active=1 and s_out=word[SIZE-1-k], so the word is sent MSB first; each edge shifts the register left by one and increments bit_cnt.
REQ-016 in_ready SHALL be 1 in SHIFT only when bit_cnt==SIZE-1; this allows gapless back-to-back frames.
REQ-017 At the edge ending SHIFT cycle SIZE-1: if a word is accepted, the block reloads and stays in SHIFT with bit_cnt=0; otherwise it goes to IDLE.
REQ-018 frame_done SHALL be registered, high for exactly one cycle: the cycle after the last bit's edge, including during back-to-back frames.
REQ-019 abort=1 at an edge SHALL force IDLE, clear bit_cnt and the shift register, and suppress frame_done; no word is accepted on that edge.
REQ-020 abort SHALL have priority over accept when both occur on the same edge.
REQ-021 in_data SHALL be sampled only on the accepting edge; changes to it during SHIFT SHALL have no effect.
REQ-022 Every SIZE-bit frame SHALL take exactly SIZE cycles, with a latency of SIZE+1 cycles from the accept edge to frame_done high.

Reset
REQ-023 While reset=1: FSM=IDLE, shift register=0, bit_cnt=0, s_out=0, s_active=0, frame_done=0; in_ready=1 only after reset is deasserted.
REQ-024 Reset asserted mid-frame SHALL discard the frame and SHALL NOT produce frame_done.

Structure
REQ-025 The state encoding (IDLE=0, SHIFT=1) and the SIZE default SHALL live in a shared include/package also used by sipo_shift_register benches.
REQ-026 The block SHALL be a single module with no sub-modules; the bit counter and FSM SHALL be inline.

Verification
REQ-027 The bench SHALL cover: SIZE=8, accept 0xA5 -> s_out 1,0,1,0,0,1,0,1 over 8 cycles; frame_done high in cycle 9 only.
REQ-028 The bench SHALL cover: SIZE=256 chained to sipo_shift_register, random word -> p_out equals the word in the frame_done cycle.
REQ-029 The bench SHALL cover: SIZE=8, in_valid held with 0x3C then 0xC3 -> 16 contiguous s_active cycles, in_ready high only on the cycles with bit_cnt=7, two frame_done pulses 8 cycles apart.
REQ-030 The bench SHALL cover: SIZE=8, abort in cycle 3 of 0xFF -> s_out=0 and s_active=0 from the next cycle, no frame_done, in_ready=1.
REQ-031 The bench SHALL cover: SIZE=8, reset asserted mid-frame in cycle 5 -> all outputs 0 immediately, no frame_done; after release, 0x81 serializes correctly.
REQ-032 The bench SHALL cover: in_data changed during SHIFT -> the serial output is unaffected.

Source files
------------

// File: rtl/piso_serializer_pkg.sv
// -----------------------------------------------------------------------------
// piso_serializer_pkg
//   Shared definitions for the PISO serializer and the benches of the matching
//   sipo_shift_register: FSM state encoding and default frame size.
// -----------------------------------------------------------------------------
package piso_serializer_pkg;

  // IDLE must encode as 0 and SHIFT as 1; downstream benches rely on it.
  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_e;

  localparam int unsigned SIZE_DEFAULT  = 256;
  localparam int unsigned CNT_W_DEFAULT = 8;

endpackage : piso_serializer_pkg

// File: rtl/piso_serializer.sv
// -----------------------------------------------------------------------------
// piso_serializer
//   Parallel-in / serial-out shifter. A SIZE-bit word is accepted on a
//   valid/ready handshake and sent MSB first, one bit per clk, on s_out.
//   A word may be accepted in the last bit cycle so frames run gapless.
//
// Ports
//   clk        : clock, rising edge
//   reset      : asynchronous, active-high reset
//   in_data    : parallel word, sampled only on the accepting edge
//   in_valid   : in_data is valid
//   in_ready   : block accepts a word this cycle
//   abort      : synchronous cancel of the current frame (beats accept)
//   s_out      : serial data, feeds s_in of the downstream sipo_shift_register
//   s_active   : s_out carries a frame bit this cycle
//   frame_done : one-cycle pulse, downstream register holds the full word
//
// CNT_W must satisfy 2**CNT_W >= SIZE.
// -----------------------------------------------------------------------------
module piso_serializer
  import piso_serializer_pkg::*;
#(
  parameter int unsigned SIZE  = SIZE_DEFAULT,
  parameter int unsigned CNT_W = CNT_W_DEFAULT
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [SIZE-1:0] in_data,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic            abort,
  output logic            s_out,
  output logic            s_active,
  output logic            frame_done
);

  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(SIZE - 1);

  state_e            state_q, state_d;
  logic [SIZE-1:0]   shift_q, shift_d;
  logic [CNT_W-1:0]  cnt_q,   cnt_d;
  logic              done_q,  done_d;
  logic              last_bit;
  logic              accept;

  assign last_bit = (state_q == SHIFT) && (cnt_q == LAST_BIT);

  // Ready is held low during reset so nothing is handshaken before release.
  assign in_ready = !reset && ((state_q == IDLE) || last_bit);
  assign accept   = in_valid && in_ready && !abort;

  assign s_active   = (state_q == SHIFT);
  assign s_out      = (state_q == SHIFT) && shift_q[SIZE-1];
  assign frame_done = done_q;

  // NOTE: every output of this block is assigned a default first, so no path
  // through the case/if tree leaves a variable unassigned and no latch forms.
  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;

    if (abort) begin
      state_d = IDLE;
      shift_d = '0;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (accept) begin
            state_d = SHIFT;
            shift_d = in_data;
            cnt_d   = '0;
          end
        end
        SHIFT: begin
          shift_d = shift_q << 1;
          cnt_d   = cnt_q + CNT_W'(1);
          if (last_bit) begin
            done_d = 1'b1;
            cnt_d  = '0;
            if (accept) begin
              shift_d = in_data;
            end else begin
              state_d = IDLE;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // NOTE: the wide shift register is reset too; a stale word must never reach
  // s_out after reset, so clearing it is worth the extra reset fan-out.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      shift_q <= '0;
      cnt_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments keep every register updating from the
      // pre-edge values, independent of statement order.
      state_q <= state_d;
      shift_q <= shift_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
    end
  end

endmodule : piso_serializer
